// File: rtl/vscale_mem_arbiter.sv
// Arbitrates a single-outstanding memory port between instruction fetch and data
// access, generating the core's wait/badmem handshakes and absorbing abandoned requests.
module vscale_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int XLEN         = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  imem_req,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_wait,
    output logic [XLEN-1:0]       imem_rdata,
    output logic                  imem_badmem_e,
    input  logic                  dmem_en,
    input  logic                  dmem_wen,
    input  logic [2:0]            dmem_size,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [XLEN-1:0]       dmem_wdata,
    output logic                  dmem_wait,
    output logic [XLEN-1:0]       dmem_rdata,
    output logic                  dmem_badmem_e,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [2:0]            mem_size,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_resp_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_DRAIN} state_t;

    localparam logic       OWN_I      = 1'b0;
    localparam logic       OWN_D      = 1'b1;
    localparam logic [2:0] FETCH_SIZE = 3'd2;
    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    state_t                r_state, w_state_next;
    logic                  r_owner, w_owner_next;
    logic [3:0]            r_d_streak, w_d_streak_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic                  r_wen, w_wen_next;
    logic [2:0]            r_size, w_size_next;
    logic [XLEN-1:0]       r_wdata, w_wdata_next;

    logic w_owner_req;
    logic w_grant_d;
    logic w_complete;
    logic w_i_done;
    logic w_d_done;

    assign w_owner_req = (r_owner == OWN_D) ? dmem_en : imem_req;
    // Data wins ties unless it has starved a waiting fetch for MAX_D_STREAK grants.
    assign w_grant_d   = dmem_en && (!imem_req || (r_d_streak < MAX_STREAK));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_owner    <= OWN_I;
            r_d_streak <= 4'd0;
            r_addr     <= '0;
            r_wen      <= 1'b0;
            r_size     <= 3'd0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_d_streak <= w_d_streak_next;
            r_addr     <= w_addr_next;
            r_wen      <= w_wen_next;
            r_size     <= w_size_next;
            r_wdata    <= w_wdata_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_d_streak_next = r_d_streak;
        w_addr_next     = r_addr;
        w_wen_next      = r_wen;
        w_size_next     = r_size;
        w_wdata_next    = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_owner_next    = OWN_D;
                    w_addr_next     = dmem_addr;
                    w_wen_next      = dmem_wen;
                    w_size_next     = dmem_size;
                    w_wdata_next    = dmem_wdata;
                    w_d_streak_next = !imem_req ? 4'd0 :
                                      (r_d_streak == 4'hF) ? 4'hF : r_d_streak + 4'd1;
                    w_state_next    = S_ISSUE;
                end else if (imem_req) begin
                    w_owner_next    = OWN_I;
                    w_addr_next     = imem_addr;
                    w_wen_next      = 1'b0;
                    w_size_next     = FETCH_SIZE;
                    w_wdata_next    = '0;
                    w_d_streak_next = 4'd0;
                    w_state_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!w_owner_req)
                    w_state_next = S_IDLE;
                else if (mem_req_ready)
                    w_state_next = S_RESP;
            end
            S_RESP: begin
                // A response arriving together with the drop is consumed here, not drained.
                if (mem_resp_valid)
                    w_state_next = S_IDLE;
                else if (!w_owner_req)
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (mem_resp_valid)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_complete    = !reset && (r_state == S_RESP) && mem_resp_valid;
        w_i_done      = w_complete && (r_owner == OWN_I) && imem_req;
        w_d_done      = w_complete && (r_owner == OWN_D) && dmem_en;
        imem_wait     = imem_req && !w_i_done;
        dmem_wait     = dmem_en && !w_d_done;
        imem_rdata    = mem_rdata;
        dmem_rdata    = mem_rdata;
        imem_badmem_e = w_i_done && mem_resp_err;
        dmem_badmem_e = w_d_done && mem_resp_err;
        mem_req_valid = !reset && (r_state == S_ISSUE) && w_owner_req;
        mem_addr      = r_addr;
        mem_wen       = r_wen;
        mem_size      = r_size;
        mem_wdata     = r_wdata;
    end

    a_resp_in_window: assert property (@(posedge clk) disable iff (reset)
        mem_resp_valid |-> (r_state == S_RESP || r_state == S_DRAIN));

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Scoreboard bench for vscale_mem_arbiter: expected grants and completions are queued
// by the stimulus and consumed by an independent monitor.
module tb_vscale_mem_arbiter;
    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_wait;
    logic [31:0] imem_rdata;
    logic        imem_badmem_e;
    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_wait;
    logic [31:0] dmem_rdata;
    logic        dmem_badmem_e;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [2:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_err;

    vscale_mem_arbiter #(.ADDR_WIDTH(32), .XLEN(32), .MAX_D_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_wait(imem_wait),
        .imem_rdata(imem_rdata), .imem_badmem_e(imem_badmem_e),
        .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wait(dmem_wait),
        .dmem_rdata(dmem_rdata), .dmem_badmem_e(dmem_badmem_e),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
    );

    typedef struct { logic [31:0] addr; logic wen; logic [2:0] size; logic [31:0] wdata; } grant_t;
    typedef struct { logic is_d; logic [31:0] data; logic err; } cpl_t;
    typedef struct { logic [31:0] data; logic err; int gap; } rsp_t;

    grant_t exp_grant_q[$];
    cpl_t   exp_cpl_q[$];
    rsp_t   rsp_q[$];

    int   total = 0;
    int   bad = 0;
    logic ready_en = 1'b1;
    int   rsp_cnt = 0;
    rsp_t cur_rsp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic exp_grant(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        grant_t g;
        g.addr = a; g.wen = w; g.size = s; g.wdata = d;
        exp_grant_q.push_back(g);
    endtask

    task automatic exp_rsp(input logic [31:0] d, input logic e, input int gap);
        rsp_t r;
        r.data = d; r.err = e; r.gap = gap;
        rsp_q.push_back(r);
    endtask

    task automatic exp_cpl(input logic is_d, input logic [31:0] d, input logic e);
        cpl_t c;
        c.is_d = is_d; c.data = d; c.err = e;
        exp_cpl_q.push_back(c);
    endtask

    // Called at a negedge; holds the request until completion, then drops it one negedge later.
    task automatic imem_access(input logic [31:0] a, output int lat);
        imem_req = 1'b1; imem_addr = a; lat = 0;
        for (int n = 1; n <= 60; n++) begin
            #2;
            if (!imem_wait) begin lat = n; break; end
            @(negedge clk);
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL imem_timeout: addr=%h got=no completion want=completion", a);
        end
        @(negedge clk);
        imem_req = 1'b0;
    endtask

    task automatic dmem_access(input logic w, input logic [2:0] s, input logic [31:0] a,
                               input logic [31:0] d, output int lat);
        dmem_en = 1'b1; dmem_wen = w; dmem_size = s; dmem_addr = a; dmem_wdata = d; lat = 0;
        for (int n = 1; n <= 60; n++) begin
            #2;
            if (!dmem_wait) begin lat = n; break; end
            @(negedge clk);
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL dmem_timeout: addr=%h got=no completion want=completion", a);
        end
        @(negedge clk);
        dmem_en = 1'b0; dmem_wen = 1'b0;
    endtask

    // Downstream model: one outstanding request, response 'gap' cycles after acceptance.
    initial begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
            if (reset) rsp_cnt = 0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = cur_rsp.data;
                    mem_resp_err   = cur_rsp.err;
                end
            end
            mem_req_ready = ready_en && (rsp_cnt == 0) && !reset;
            #1;
            if (mem_req_valid && mem_req_ready) begin
                total++;
                if (rsp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_avail: got=accept with empty response table want=no accept");
                    cur_rsp.data = '0; cur_rsp.err = 1'b0; cur_rsp.gap = 1;
                end else begin
                    cur_rsp = rsp_q.pop_front();
                end
                rsp_cnt = cur_rsp.gap;
            end
        end
    end

    // Monitor: compares downstream grants and requester completions against the queues.
    initial begin
        grant_t      g;
        cpl_t        c;
        logic        is_d;
        logic        done;
        logic [31:0] got_data;
        logic        got_err;
        logic        other_err;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_grant_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL grant_unexpected: got addr=%h want=no grant", mem_addr);
                    end else begin
                        g = exp_grant_q.pop_front();
                        $display("grant addr=%h wen=%0d size=%0d wdata=%h", mem_addr, mem_wen, mem_size, mem_wdata);
                        check("grant_addr", mem_addr, g.addr);
                        check("grant_wen", 32'(mem_wen), 32'(g.wen));
                        check("grant_size", 32'(mem_size), 32'(g.size));
                        check("grant_wdata", mem_wdata, g.wdata);
                    end
                end
                done = (imem_req && !imem_wait) || (dmem_en && !dmem_wait);
                if (done) begin
                    is_d      = dmem_en && !dmem_wait;
                    got_data  = is_d ? dmem_rdata : imem_rdata;
                    got_err   = is_d ? dmem_badmem_e : imem_badmem_e;
                    other_err = is_d ? imem_badmem_e : dmem_badmem_e;
                    if (exp_cpl_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL cpl_unexpected: got %s completion data=%h want=none",
                                 is_d ? "dmem" : "imem", got_data);
                    end else begin
                        c = exp_cpl_q.pop_front();
                        $display("complete %s data=%h err=%0d", is_d ? "dmem" : "imem", got_data, got_err);
                        check("cpl_src_is_d", 32'(is_d), 32'(c.is_d));
                        check("cpl_data", got_data, c.data);
                        check("cpl_err", 32'(got_err), 32'(c.err));
                        check("cpl_other_err", 32'(other_err), 32'd0);
                        check("cpl_single", 32'((imem_req && !imem_wait) && (dmem_en && !dmem_wait)), 32'd0);
                    end
                end else begin
                    check("strobe_idle", 32'(imem_badmem_e || dmem_badmem_e), 32'd0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat_i;
        int lat_d;
        reset = 1'b1; imem_req = 1'b0; imem_addr = '0;
        dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0; dmem_addr = '0; dmem_wdata = '0;
        repeat (2) @(negedge clk);
        imem_req = 1'b1; dmem_en = 1'b1;
        #2;
        check("rst_imem_wait", 32'(imem_wait), 32'd1);
        check("rst_dmem_wait", 32'(dmem_wait), 32'd1);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_badmem", 32'(imem_badmem_e || dmem_badmem_e), 32'd0);
        @(negedge clk);
        imem_req = 1'b0; dmem_en = 1'b0; reset = 1'b0;
        #2;
        check("post_rst_valid", 32'(mem_req_valid), 32'd0);
        check("post_rst_addr", mem_addr, 32'd0);
        check("post_rst_wen", 32'(mem_wen), 32'd0);
        check("post_rst_size", 32'(mem_size), 32'd0);
        check("post_rst_wdata", mem_wdata, 32'd0);
        @(negedge clk);

        // Single fetch, minimum latency.
        exp_grant(32'h200, 1'b0, 3'd2, 32'h0);
        exp_rsp(32'h00000013, 1'b0, 1);
        exp_cpl(1'b0, 32'h00000013, 1'b0);
        imem_access(32'h200, lat_i);
        check("fetch_latency", 32'(lat_i), 32'd3);

        // Simultaneous store and fetch: data first.
        exp_grant(32'h1000, 1'b1, 3'd2, 32'hDEADBEEF);
        exp_grant(32'h204, 1'b0, 3'd2, 32'h0);
        exp_rsp(32'h0, 1'b0, 1);
        exp_rsp(32'h00100093, 1'b0, 1);
        exp_cpl(1'b1, 32'h0, 1'b0);
        exp_cpl(1'b0, 32'h00100093, 1'b0);
        fork
            imem_access(32'h204, lat_i);
            dmem_access(1'b1, 3'd2, 32'h1000, 32'hDEADBEEF, lat_d);
        join

        // Streak limit: D,D,D,D,I then streak restarts so D,D precede the next fetch.
        for (int i = 0; i < 4; i++) exp_grant(32'h2000 + 32'(4 * i), 1'b0, 3'd2, 32'h0);
        exp_grant(32'h300, 1'b0, 3'd2, 32'h0);
        exp_grant(32'h2010, 1'b0, 3'd2, 32'h0);
        exp_grant(32'h2014, 1'b0, 3'd2, 32'h0);
        exp_grant(32'h304, 1'b0, 3'd2, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_rsp(32'h11110000 + 32'(i), 1'b0, 1);
            exp_cpl(1'b1, 32'h11110000 + 32'(i), 1'b0);
        end
        exp_rsp(32'h00000513, 1'b0, 1);  exp_cpl(1'b0, 32'h00000513, 1'b0);
        exp_rsp(32'h11110004, 1'b0, 1);  exp_cpl(1'b1, 32'h11110004, 1'b0);
        exp_rsp(32'h11110005, 1'b0, 1);  exp_cpl(1'b1, 32'h11110005, 1'b0);
        exp_rsp(32'h00000593, 1'b0, 1);  exp_cpl(1'b0, 32'h00000593, 1'b0);
        fork
            begin
                imem_access(32'h300, lat_i);
                imem_access(32'h304, lat_i);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    int l;
                    dmem_access(1'b0, 3'd2, 32'h2000 + 32'(4 * i), 32'h0, l);
                end
            end
        join

        // Fetch abandoned after acceptance: its late response must be drained.
        exp_grant(32'h400, 1'b0, 3'd2, 32'h0);
        exp_rsp(32'hAAAA5555, 1'b0, 3);
        imem_req = 1'b1; imem_addr = 32'h400;
        lat_i = 0;
        for (int n = 1; n <= 20; n++) begin
            #2;
            if (mem_req_valid && mem_req_ready) begin lat_i = n; break; end
            @(negedge clk);
        end
        check("drain_accept_seen", 32'(lat_i != 0), 32'd1);
        @(negedge clk);
        imem_req = 1'b0;
        @(negedge clk);
        exp_grant(32'h404, 1'b0, 3'd2, 32'h0);
        exp_rsp(32'h00C00093, 1'b0, 1);
        exp_cpl(1'b0, 32'h00C00093, 1'b0);
        imem_access(32'h404, lat_i);
        check("after_drain_latency", 32'(lat_i), 32'd5);

        // Load with bus error.
        exp_grant(32'h3000, 1'b0, 3'd2, 32'h0);
        exp_rsp(32'hBAD0BAD0, 1'b1, 1);
        exp_cpl(1'b1, 32'hBAD0BAD0, 1'b1);
        dmem_access(1'b0, 3'd2, 32'h3000, 32'h0, lat_d);
        check("err_latency", 32'(lat_d), 32'd3);

        // Reset while a request sits in ISSUE with downstream stalled.
        ready_en = 1'b0;
        @(negedge clk);
        dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h5000;
        @(negedge clk);
        #2;
        check("stall_issue_valid", 32'(mem_req_valid), 32'd1);
        check("stall_issue_addr", mem_addr, 32'h5000);
        @(negedge clk);
        reset = 1'b1; imem_req = 1'b1;
        @(negedge clk);
        #2;
        check("midrst_valid", 32'(mem_req_valid), 32'd0);
        check("midrst_dmem_wait", 32'(dmem_wait), 32'd1);
        check("midrst_imem_wait", 32'(imem_wait), 32'd1);
        check("midrst_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0; dmem_en = 1'b0; imem_req = 1'b0; ready_en = 1'b1;
        repeat (4) @(negedge clk);

        check("left_grants", 32'(exp_grant_q.size()), 32'd0);
        check("left_cpls", 32'(exp_cpl_q.size()), 32'd0);
        check("left_rsps", 32'(rsp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
